// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree
//   Sums N = 2**LEVELS unsigned WIDTH-bit operands through a binary adder tree.
//   The tree result is either passed out directly (tree mode) or added into a
//   wrapping accumulator with a sticky overflow flag (accumulate mode).
//   PIPE=1 registers every tree level; PIPE=0 registers only the tree root.
//   Latency is 1 + (PIPE ? LEVELS : 1) + 1 cycles; one sample per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   in_valid   in_data / acc_mode / acc_clear are valid this cycle
//   in_data    N operands, operand k at [k*WIDTH +: WIDTH]
//   acc_mode   0 = tree sum, 1 = accumulate
//   acc_clear  in accumulate mode, restart the accumulator at this sample
//   out_valid  one-cycle pulse per result
//   out_sum    result, held between pulses
//   acc_ovf    sticky accumulator wrap flag
module pipelined_adder_tree #(
  parameter int WIDTH    = 11,
  parameter int LEVELS   = 3,
  parameter int PIPE     = 1,
  parameter int ACC_BITS = 4,
  localparam int N       = 2**LEVELS,
  localparam int SUM_W   = WIDTH + LEVELS,
  localparam int OUT_W   = SUM_W + ACC_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               acc_mode,
  input  logic               acc_clear,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_sum,
  output logic               acc_ovf
);

  // Full-tree reduction used when the tree is not pipelined. Node values at
  // level j never exceed WIDTH+j bits, so the SUM_W-wide adds are exact.
  function automatic logic [SUM_W-1:0] tree_sum(input logic [N*WIDTH-1:0] ops);
    logic [SUM_W-1:0] node [N];
    for (int k = 0; k < N; k++) node[k] = SUM_W'(ops[k*WIDTH +: WIDTH]);
    for (int j = 1; j <= LEVELS; j++)
      for (int k = 0; k < (N >> j); k++) node[k] = node[2*k] + node[2*k+1];
    return node[0];
  endfunction

  // Accumulator add; the extra MSB is the carry out of OUT_W bits.
  function automatic logic [OUT_W:0] acc_add(input logic [OUT_W-1:0] acc_val,
                                             input logic [SUM_W-1:0] addend);
    return {1'b0, acc_val} + (OUT_W+1)'(addend);
  endfunction

  // ---- stage p0: input capture ----
  logic [N*WIDTH-1:0] data_p0;
  logic               vld_p0, mode_p0, clr_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      mode_p0 <= 1'b0;
      clr_p0  <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        data_p0 <= in_data;
        mode_p0 <= acc_mode;
        clr_p0  <= acc_clear;
      end
    end
  end

  // ---- stage p1: adder tree ----
  logic [SUM_W-1:0] root_p1;
  logic             rvld_p1, rmode_p1, rclr_p1;

  if (PIPE != 0) begin : g_pipe
    // Level j keeps N>>j live nodes; higher indices stay at zero. Stored
    // SUM_W wide, upper bits of lower levels are constant zero.
    logic [SUM_W-1:0] lvl_p1  [1:LEVELS][N];
    logic             vld_p1  [1:LEVELS];
    logic             mode_p1 [1:LEVELS];
    logic             clr_p1  [1:LEVELS];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int j = 1; j <= LEVELS; j++) begin
          vld_p1[j]  <= 1'b0;
          mode_p1[j] <= 1'b0;
          clr_p1[j]  <= 1'b0;
          for (int k = 0; k < N; k++) lvl_p1[j][k] <= '0;
        end
      end else begin
        vld_p1[1] <= vld_p0;
        if (vld_p0) begin
          mode_p1[1] <= mode_p0;
          clr_p1[1]  <= clr_p0;
          for (int k = 0; k < N/2; k++)
            lvl_p1[1][k] <= SUM_W'(data_p0[2*k*WIDTH +: WIDTH])
                          + SUM_W'(data_p0[(2*k+1)*WIDTH +: WIDTH]);
        end
        for (int j = 2; j <= LEVELS; j++) begin
          vld_p1[j] <= vld_p1[j-1];
          if (vld_p1[j-1]) begin
            mode_p1[j] <= mode_p1[j-1];
            clr_p1[j]  <= clr_p1[j-1];
            for (int k = 0; k < (N >> j); k++)
              lvl_p1[j][k] <= lvl_p1[j-1][2*k] + lvl_p1[j-1][2*k+1];
          end
        end
      end
    end

    assign root_p1  = lvl_p1[LEVELS][0];
    assign rvld_p1  = vld_p1[LEVELS];
    assign rmode_p1 = mode_p1[LEVELS];
    assign rclr_p1  = clr_p1[LEVELS];
  end else begin : g_flat
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rvld_p1  <= 1'b0;
        root_p1  <= '0;
        rmode_p1 <= 1'b0;
        rclr_p1  <= 1'b0;
      end else begin
        rvld_p1 <= vld_p0;
        if (vld_p0) begin
          root_p1  <= tree_sum(data_p0);
          rmode_p1 <= mode_p0;
          rclr_p1  <= clr_p0;
        end
      end
    end
  end

  // ---- stage p2: output / accumulator ----
  logic [OUT_W-1:0] acc_p2, sum_p2;
  logic             vld_p2, ovf_p2;
  logic [OUT_W:0]   acc_next;

  assign acc_next = acc_add(acc_p2, root_p1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      acc_p2 <= '0;
      sum_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else begin
      vld_p2 <= rvld_p1;
      if (rvld_p1) begin
        if (!rmode_p1) begin
          // tree mode: clear flag is meaningless here, accumulator untouched
          sum_p2 <= OUT_W'(root_p1);
        end else if (rclr_p1) begin
          acc_p2 <= OUT_W'(root_p1);
          sum_p2 <= OUT_W'(root_p1);
          ovf_p2 <= 1'b0;
        end else begin
          acc_p2 <= acc_next[OUT_W-1:0];
          sum_p2 <= acc_next[OUT_W-1:0];
          if (acc_next[OUT_W]) ovf_p2 <= 1'b1;
        end
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_sum   = sum_p2;
  assign acc_ovf   = ovf_p2;

endmodule

// File: doc/pipelined_adder_tree.md
PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

Interface
REQ-001 SHALL have parameter WIDTH, default 11, unsigned bit width of each input operand.
REQ-002 SHALL have parameter LEVELS, default 3, tree depth; input count N = 2**LEVELS; legal range 1..6.
REQ-003 SHALL have parameter PIPE, default 1; 1 = register after every tree level, 0 = one register after the whole tree.
REQ-004 SHALL have parameter ACC_BITS, default 4, accumulator headroom bits.
REQ-005 SHALL define local width SUM_W = WIDTH+LEVELS and OUT_W = SUM_W+ACC_BITS.
REQ-006 Ports, in order:
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 in_valid  input  1  in_data, acc_mode and acc_clear are valid this cycle.
REQ-010 in_data  input  N*WIDTH  operand k at bits [k*WIDTH +: WIDTH], unsigned.
REQ-011 acc_mode  input  1  0 = tree sum, 1 = accumulate.
REQ-012 acc_clear  input  1  with acc_mode=1: restart the accumulator at this sample.
REQ-013 out_valid  output  1  out_sum holds a new result.
REQ-014 out_sum  output  OUT_W  result, registered.
REQ-015 acc_ovf  output  1  sticky accumulator wrap flag, registered.

Function
REQ-016 SHALL register in_data, acc_mode, acc_clear when in_valid=1 (input stage); a valid bit SHALL travel with every stage.
REQ-017 Level j adders SHALL be WIDTH+j-1 bits in, WIDTH+j bits out, no truncation; the root sum SHALL be SUM_W bits, exact.
REQ-018 Latency in_valid -> out_valid SHALL be LAT = 1 + (PIPE ? LEVELS : 1) + 1 cycles: input stage, tree stage(s), output stage (default LAT = 5).
REQ-019 Throughput SHALL be one sample per cycle; no backpressure; every accepted sample SHALL produce exactly one out_valid pulse, in order.
REQ-020 Stages holding invalid samples SHALL NOT update out_sum, accumulator, or acc_ovf; out_sum SHALL hold its last value while out_valid=0.
REQ-021 acc_mode and acc_clear SHALL be pipelined with their own sample; changing them mid-stream SHALL affect only that sample and later ones.
REQ-022 Tree mode (acc_mode=0): out_sum SHALL equal the root sum zero-extended to OUT_W; the accumulator SHALL be left unchanged.
REQ-023 Accumulate mode, acc_clear=0: acc <= acc + root sum mod 2**OUT_W; out_sum <= the new acc.
REQ-024 Accumulate mode, acc_clear=1: acc <= root sum; out_sum <= root sum; acc_ovf <= 0.
REQ-025 acc_ovf SHALL be set when an accumulate (clear=0) add carries out of OUT_W bits and SHALL stay set until a clearing sample or reset.
REQ-026 acc_clear with acc_mode=0 SHALL be ignored.
REQ-027 out_valid SHALL be high for exactly one cycle per result.

Reset
REQ-028 reset=1 SHALL asynchronously clear all valid bits, accumulator, out_sum, acc_ovf, and pipeline registers to 0.
REQ-029 out_valid, out_sum, acc_ovf SHALL read 0 during reset and until the first post-reset result.
REQ-030 Samples in flight at reset assertion SHALL be discarded, producing no out_valid.
REQ-031 A sample presented in the first cycle after reset deasserts SHALL be accepted normally.

Verification (defaults: WIDTH=11, LEVELS=3, PIPE=1, ACC_BITS=4, OUT_W=18, LAT=5)
REQ-032 All 8 operands 2047, acc_mode=0, one cycle -> out_valid pulse 5 cycles later, out_sum=16376, acc_ovf=0.
REQ-033 Operands 0..7, mode=0, then 8 back-to-back samples with operand0 = 1..8 (others 0) -> sums 28,1,2,...,8 on 9 consecutive cycles, in order.
REQ-034 mode=1: clear sample of all 1s, then 3 samples of all 1s -> out_sum 8,16,24,32; then a mode=0 sample of all 2s -> 16; next mode=1 sample of all 1s -> 40.
REQ-035 mode=1, clear with all operands 2047, then 16 more samples of all 2047 (17 x 16376 = 278392 > 262143) -> acc_ovf rises on the 16th result, out_sum = 278392 mod 262144 = 16248; next clear sample -> acc_ovf=0.
REQ-036 Issue 3 samples, assert reset 2 cycles later for 1 cycle mid-flight -> no out_valid from those samples, out_sum=0, acc=0; new sample of all 1s -> out_sum=8 after 5 cycles.
REQ-037 Repeat REQ-032 and REQ-034 with PIPE=0 (LAT=3) and with LEVELS=1, WIDTH=4 (N=2, 2 operands of 15 -> 30).
